div_unit: RTL



---
 rtl/cpu_pkg.sv | 31 +++
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the divider and its datapath step.
//   DIV_WIDTH        default operand/result width
//   DIV_OP_*         2-bit M-extension divide opcode encodings
//   div_state_e      divider control states
//   div_op_signed()  1 for DIV/REM (bit 0 clear)
//   div_op_rem()     1 for REM/REMU (bit 1 set)
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic div_op_signed(input logic [1:0] op_i);
    return ~op_i[0];
  endfunction

  function automatic logic div_op_rem(input logic [1:0] op_i);
    return op_i[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
// Ports:
//   i_rem  partial remainder before the step
//   i_quo  quotient register before the step (dividend bits shift out of its MSB)
//   i_div  divisor magnitude
//   o_rem  partial remainder after the step
//   o_quo  quotient register after the step (new quotient bit in the LSB)
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic        [WIDTH:0] w_shift;
  logic signed [WIDTH:0] w_trial;

  // Since rem < divisor before the step, the true trial value lies in
  // [-divisor, divisor-1], so WIDTH+1 bits hold it and its MSB is the sign.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_div};

  assign o_rem = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Operands come from the register file read ports and the result goes back
// through the register file write port. busy stalls the pipeline while the
// divider is not idle.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           request, sampled only in IDLE
//   op, rd          opcode and destination register, latched with start
//   busA, busB      dividend and divisor, latched with start
//   busy            high in every state except IDLE
//   wren, rw, busW  one-cycle register file write (suppressed when rd = 0)
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [REGADDR-1:0] rd,
  input  logic [WIDTH-1:0]   busA,
  input  logic [WIDTH-1:0]   busB,
  output logic               busy,
  output logic               wren,
  output logic [REGADDR-1:0] rw,
  output logic [WIDTH-1:0]   busW
);

  localparam int                CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_is_rem;
  logic               r_qneg;
  logic               r_rneg;
  logic [REGADDR-1:0] r_rd;
  logic               r_busy;
  logic               r_wren;
  logic [REGADDR-1:0] r_rw;
  logic [WIDTH-1:0]   r_busW;

  logic               w_signed;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_div0;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_special;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  // Two's complement negation when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic neg,
                                                input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign w_signed = div_op_signed(op);
  assign w_absA   = cond_neg(w_signed & busA[WIDTH-1], busA);
  assign w_absB   = cond_neg(w_signed & busB[WIDTH-1], busB);
  assign w_div0   = (busB == '0);
  assign w_ovf    = w_signed & (busA == MIN_NEG) & (busB == '1);

  // Results that bypass the iteration: divide by zero and signed overflow.
  always_comb begin
    w_special = '0;
    if (w_div0)
      w_special = div_op_rem(op) ? busA : '1;
    else
      w_special = div_op_rem(op) ? '0 : MIN_NEG;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  assign w_q_fix = cond_neg(r_qneg, r_quo);
  assign w_r_fix = cond_neg(r_rneg, r_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_is_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_rd     <= '0;
      r_busy   <= 1'b0;
      r_wren   <= 1'b0;
      r_rw     <= '0;
      r_busW   <= '0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_is_rem <= div_op_rem(op);
            r_rd     <= rd;
            r_div    <= w_absB;
            r_qneg   <= w_signed & (busA[WIDTH-1] ^ busB[WIDTH-1]);
            r_rneg   <= w_signed & busA[WIDTH-1];
            r_count  <= '0;
            r_busy   <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_busW  <= w_special;
              r_rw    <= rd;
              r_wren  <= (rd != '0);
              r_state <= DIV_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_absA;
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_rem   <= w_step_rem;
          r_quo   <= w_step_quo;
          r_count <= r_count + 1'b1;
          if (r_count == LAST)
            r_state <= DIV_FIX;
        end
        DIV_FIX: begin
          r_busW  <= r_is_rem ? w_r_fix : w_q_fix;
          r_rw    <= r_rd;
          r_wren  <= (r_rd != '0);
          r_state <= DIV_DONE;
        end
        DIV_DONE: begin
          r_busy  <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign wren = r_wren;
  assign rw   = r_rw;
  assign busW = r_busW;

endmodule
